// File: rtl/clkgen_multi.sv
// clkgen_multi: NUM_CH programmable clock-enable / waveform generators.
// Shared config port with per-channel shadow registers applied at period wrap.

module clkgen_ch #(
    parameter int CNT_W      = 8,
    parameter int DEF_PERIOD = 2,
    parameter int DEF_HIGH   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             ld,
    input  logic [CNT_W-1:0] ld_period,
    input  logic [CNT_W-1:0] ld_high,
    output logic             pending,
    output logic             wave,
    output logic             rise,
    output logic             fall
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [CNT_W-1:0] ZERO  = '0;
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DPER  = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DHIGH = CNT_W'(DEF_HIGH);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] shp_q, shp_d;
    logic [CNT_W-1:0] shh_q, shh_d;
    logic             pend_q, pend_d;
    logic             wave_q, wave_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             wrap;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= ZERO;
            per_q   <= DPER;
            high_q  <= DHIGH;
            shp_q   <= DPER;
            shh_q   <= DHIGH;
            pend_q  <= 1'b0;
            wave_q  <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            high_q  <= high_d;
            shp_q   <= shp_d;
            shh_q   <= shh_d;
            pend_q  <= pend_d;
            wave_q  <= wave_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign wrap = (cnt_q == per_q - ONE);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        per_d   = per_q;
        high_d  = high_q;
        shp_d   = shp_q;
        shh_d   = shh_q;
        pend_d  = pend_q;
        wave_d  = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = ZERO;
                if (pend_q) begin
                    per_d  = shp_q;
                    high_d = shh_q;
                    pend_d = 1'b0;
                end
                if (enable) state_d = RUN;
            end
            RUN: begin
                if (!enable) begin
                    // Output drops right away; any shadow applies once IDLE.
                    state_d = IDLE;
                    cnt_d   = ZERO;
                end else begin
                    wave_d = (cnt_q < high_q);
                    if (wrap) begin
                        cnt_d = ZERO;
                        if (pend_q) begin
                            per_d  = shp_q;
                            high_d = shh_q;
                            pend_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
            end
        endcase
        // A load is only granted while no shadow is pending.
        if (ld) begin
            pend_d = 1'b1;
            shp_d  = ld_period;
            shh_d  = ld_high;
        end
        rise_d = wave_d && !wave_q;
        fall_d = !wave_d && wave_q;
    end

    assign pending = pend_q;
    assign wave    = wave_q;
    assign rise    = rise_q;
    assign fall    = fall_q;

endmodule

module clkgen_multi #(
    parameter int NUM_CH     = 4,
    parameter int CNT_W      = 8,
    parameter int DEF_PERIOD = 2,
    parameter int DEF_HIGH   = 1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NUM_CH-1:0] enable,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_period,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic              cfg_err,
    output logic [NUM_CH-1:0] wave_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse
);

    logic [NUM_CH-1:0] pend;
    logic              ch_ok;
    logic              sel_pend;
    logic              bad;
    logic              hs;
    logic              err_q;

    assign ch_ok    = (int'(cfg_ch) < NUM_CH);
    assign sel_pend = ch_ok ? pend[cfg_ch] : 1'b0;
    assign bad      = (cfg_period < CNT_W'(2))
                   || (cfg_high > cfg_period)
                   || !ch_ok;
    assign cfg_ready = !reset && !sel_pend;
    assign hs        = cfg_valid && cfg_ready;

    // Rejected requests still complete the handshake; only the pulse reports them.
    always_ff @(posedge clock) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= hs && bad;
    end

    assign cfg_err = err_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic ld;
        assign ld = hs && !bad && (int'(cfg_ch) == i);

        clkgen_ch #(
            .CNT_W      (CNT_W),
            .DEF_PERIOD (DEF_PERIOD),
            .DEF_HIGH   (DEF_HIGH)
        ) u_ch (
            .clock     (clock),
            .reset     (reset),
            .enable    (enable[i]),
            .ld        (ld),
            .ld_period (cfg_period),
            .ld_high   (cfg_high),
            .pending   (pend[i]),
            .wave      (wave_out[i]),
            .rise      (rise_pulse[i]),
            .fall      (fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_clkgen_multi.sv
// Bench for clkgen_multi: directed scenarios plus random traffic
// compared cycle by cycle against a phase-arithmetic reference model.

module tb_clkgen_multi;

    localparam int NCH = 3;
    localparam int W   = 8;
    localparam int CHW = 2;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [NCH-1:0] enable = '0;
    logic           cfg_valid = 1'b0;
    logic           cfg_ready;
    logic [CHW-1:0] cfg_ch = '0;
    logic [W-1:0]   cfg_period = '0;
    logic [W-1:0]   cfg_high = '0;
    logic           cfg_err;
    logic [NCH-1:0] wave_out, rise_pulse, fall_pulse;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [NCH-1:0] m_on, m_pend, m_wave, m_rise, m_fall;
    logic           m_err;
    int m_age[NCH];
    int m_per[NCH];
    int m_high[NCH];
    int m_sp[NCH];
    int m_sh[NCH];

    clkgen_multi #(
        .NUM_CH     (NCH),
        .CNT_W      (W),
        .DEF_PERIOD (2),
        .DEF_HIGH   (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_err    (cfg_err),
        .wave_out   (wave_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse)
    );

    always #5 clock = ~clock;

    function automatic logic exp_ready();
        logic p;
        p = (int'(cfg_ch) < NCH) ? m_pend[cfg_ch] : 1'b0;
        return !reset && !p;
    endfunction

    // Waveform position is (cycles since segment start) mod period.
    task automatic model_step();
        logic hs, bad, nw;
        int ph;
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                m_on[i] = 0; m_pend[i] = 0; m_wave[i] = 0;
                m_rise[i] = 0; m_fall[i] = 0;
                m_age[i] = 0; m_per[i] = 2; m_high[i] = 1;
            end
            m_err = 0;
            return;
        end
        hs  = cfg_valid && exp_ready();
        bad = (cfg_period < 2) || (cfg_high > cfg_period)
           || (int'(cfg_ch) >= NCH);
        m_err = hs && bad;
        for (int i = 0; i < NCH; i++) begin
            nw = 0;
            if (m_on[i] && enable[i]) begin
                ph = m_age[i] % m_per[i];
                nw = (ph < m_high[i]);
                m_age[i]++;
                if (ph == m_per[i] - 1 && m_pend[i]) begin
                    m_per[i] = m_sp[i]; m_high[i] = m_sh[i];
                    m_pend[i] = 0; m_age[i] = 0;
                end
            end else if (m_on[i]) begin
                m_on[i] = 0;
            end else begin
                if (m_pend[i]) begin
                    m_per[i] = m_sp[i]; m_high[i] = m_sh[i];
                    m_pend[i] = 0;
                end
                if (enable[i]) begin
                    m_on[i] = 1; m_age[i] = 0;
                end
            end
            m_rise[i] = nw && !m_wave[i];
            m_fall[i] = !nw && m_wave[i];
            m_wave[i] = nw;
            if (hs && !bad && int'(cfg_ch) == i) begin
                m_pend[i] = 1;
                m_sp[i] = int'(cfg_period);
                m_sh[i] = int'(cfg_high);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic send(input int ch, input int p, input int h);
        cfg_valid  = 1'b1;
        cfg_ch     = CHW'(ch);
        cfg_period = W'(p);
        cfg_high   = W'(h);
        tick();
        cfg_valid  = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        enable = '0;
        tick();
        tick();
        checks++;
        if ({wave_out, rise_pulse, fall_pulse, cfg_err} !== '0) begin
            errors++;
            $display("FAIL reset_outs got %b exp 0",
                     {wave_out, rise_pulse, fall_pulse, cfg_err});
        end
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready got %b exp 0", cfg_ready);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_after_reset got %b exp 1", cfg_ready);
        end
    endtask

    task automatic test_default();
        int rises = 0;
        enable[0] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if ({wave_out, rise_pulse, fall_pulse, cfg_err}
                !== {m_wave, m_rise, m_fall, m_err}) begin
                errors++;
                $display("FAIL default k=%0d got %b exp %b", k,
                         {wave_out, rise_pulse, fall_pulse, cfg_err},
                         {m_wave, m_rise, m_fall, m_err});
            end
            if (k == 1) begin
                checks++;
                if ({wave_out[0], rise_pulse[0]} !== 2'b11) begin
                    errors++;
                    $display("FAIL first_rise got %b exp 11",
                             {wave_out[0], rise_pulse[0]});
                end
            end
            rises += int'(rise_pulse[0]);
        end
        checks++;
        if (rises != 6) begin
            errors++;
            $display("FAIL default_rises got %0d exp 6", rises);
        end
    endtask

    task automatic test_cfg_idle();
        int r1 = -1, r2 = -1, f1 = -1;
        send(1, 5, 2);
        tick();
        enable[1] = 1'b1;
        for (int k = 0; k < 24; k++) begin
            tick();
            checks++;
            if ({wave_out, rise_pulse, fall_pulse, cfg_err}
                !== {m_wave, m_rise, m_fall, m_err}) begin
                errors++;
                $display("FAIL cfg_idle k=%0d got %b exp %b", k,
                         {wave_out, rise_pulse, fall_pulse, cfg_err},
                         {m_wave, m_rise, m_fall, m_err});
            end
            if (rise_pulse[1] === 1'b1) begin
                if (r1 < 0) r1 = k;
                else if (r2 < 0) r2 = k;
            end
            if (fall_pulse[1] === 1'b1 && r1 >= 0 && f1 < 0) f1 = k;
        end
        checks++;
        if (r1 < 0 || r2 - r1 != 5 || f1 - r1 != 2) begin
            errors++;
            $display("FAIL cfg_idle_timing got r1=%0d r2=%0d f1=%0d exp spacing 5 offset 2",
                     r1, r2, f1);
        end
    endtask

    task automatic test_update();
        int r0 = -1, r1 = -1, r2 = -1;
        for (int k = 0; k < 10 && rise_pulse[1] !== 1'b1; k++) tick();
        checks++;
        if (rise_pulse[1] !== 1'b1) begin
            errors++;
            $display("FAIL update_wait got %b exp 1 (timeout)", rise_pulse[1]);
        end
        r0 = cyc;
        tick();
        cfg_valid = 1'b1; cfg_ch = 2'd1;
        cfg_period = 8'd3; cfg_high = 8'd1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL update_ready1 got %b exp 1", cfg_ready);
        end
        tick();
        cfg_period = 8'd4; cfg_high = 8'd2;
        #1;
        checks++;
        if (cfg_ready !== 1'b0 || exp_ready() !== 1'b0) begin
            errors++;
            $display("FAIL update_busy got %b exp 0", cfg_ready);
        end
        tick();
        cfg_valid = 1'b0;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if ({wave_out, rise_pulse, fall_pulse, cfg_err}
                !== {m_wave, m_rise, m_fall, m_err}) begin
                errors++;
                $display("FAIL update k=%0d got %b exp %b", k,
                         {wave_out, rise_pulse, fall_pulse, cfg_err},
                         {m_wave, m_rise, m_fall, m_err});
            end
            if (rise_pulse[1] === 1'b1) begin
                if (r1 < 0) r1 = cyc;
                else if (r2 < 0) r2 = cyc;
            end
            tick();
        end
        checks++;
        if (r1 - r0 != 5 || r2 - r1 != 3) begin
            errors++;
            $display("FAIL update_periods got %0d,%0d exp 5,3", r1 - r0, r2 - r1);
        end
    endtask

    task automatic test_errors();
        int ec[3] = '{1, 1, 3};
        int ep[3] = '{1, 4, 2};
        int eh[3] = '{0, 6, 1};
        for (int j = 0; j < 3; j++) begin
            cfg_valid = 1'b1; cfg_ch = CHW'(ec[j]);
            cfg_period = W'(ep[j]); cfg_high = W'(eh[j]);
            #1;
            checks++;
            if (cfg_ready !== 1'b1) begin
                errors++;
                $display("FAIL err_ready%0d got %b exp 1", j, cfg_ready);
            end
            tick();
            cfg_valid = 1'b0;
            checks++;
            if (cfg_err !== 1'b1 || {wave_out, rise_pulse, fall_pulse}
                !== {m_wave, m_rise, m_fall}) begin
                errors++;
                $display("FAIL err_pulse%0d got %b exp 1", j, cfg_err);
            end
            tick();
            checks++;
            if (cfg_err !== 1'b0 || {wave_out, rise_pulse, fall_pulse}
                !== {m_wave, m_rise, m_fall}) begin
                errors++;
                $display("FAIL err_clear%0d got %b exp 0", j, cfg_err);
            end
        end
    endtask

    task automatic test_disable();
        enable[2] = 1'b1;
        for (int k = 0; k < 8 && wave_out[2] !== 1'b1; k++) tick();
        checks++;
        if (wave_out[2] !== 1'b1) begin
            errors++;
            $display("FAIL disable_wait got %b exp 1 (timeout)", wave_out[2]);
        end
        enable[2] = 1'b0;
        tick();
        checks++;
        if ({wave_out[2], rise_pulse[2], fall_pulse[2]} !== 3'b001
            || fall_pulse !== m_fall) begin
            errors++;
            $display("FAIL disable_fall got %b exp 001",
                     {wave_out[2], rise_pulse[2], fall_pulse[2]});
        end
        tick();
        checks++;
        if ({wave_out[2], rise_pulse[2], fall_pulse[2]} !== 3'b000) begin
            errors++;
            $display("FAIL disable_idle got %b exp 000",
                     {wave_out[2], rise_pulse[2], fall_pulse[2]});
        end
        enable[2] = 1'b1;
        tick();
        checks++;
        if (wave_out[2] !== 1'b0) begin
            errors++;
            $display("FAIL reenable_0 got %b exp 0", wave_out[2]);
        end
        tick();
        checks++;
        if ({wave_out[2], rise_pulse[2]} !== 2'b11
            || wave_out !== m_wave) begin
            errors++;
            $display("FAIL reenable_1 got %b exp 11",
                     {wave_out[2], rise_pulse[2]});
        end
    endtask

    task automatic test_reset_mid();
        int r1 = -1, r2 = -1;
        enable = 3'b010;
        tick();
        send(1, 7, 3);
        reset = 1'b1;
        tick();
        checks++;
        if ({wave_out, rise_pulse, fall_pulse, cfg_err} !== '0
            || cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL midreset got %b rdy %b exp 0",
                     {wave_out, rise_pulse, fall_pulse, cfg_err}, cfg_ready);
        end
        reset = 1'b0;
        cfg_ch = 2'd1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_shadow got %b exp 1", cfg_ready);
        end
        for (int k = 0; k < 12; k++) begin
            tick();
            checks++;
            if ({wave_out, rise_pulse, fall_pulse, cfg_err}
                !== {m_wave, m_rise, m_fall, m_err}) begin
                errors++;
                $display("FAIL midreset k=%0d got %b exp %b", k,
                         {wave_out, rise_pulse, fall_pulse, cfg_err},
                         {m_wave, m_rise, m_fall, m_err});
            end
            if (rise_pulse[1] === 1'b1) begin
                if (r1 < 0) r1 = k;
                else if (r2 < 0) r2 = k;
            end
        end
        checks++;
        if (r1 < 0 || r2 - r1 != 2) begin
            errors++;
            $display("FAIL midreset_default got %0d exp 2", r2 - r1);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 1500; k++) begin
            for (int i = 0; i < NCH; i++)
                if ($urandom_range(0, 15) == 0) enable[i] = ~enable[i];
            reset      = ($urandom_range(0, 299) == 0);
            cfg_valid  = ($urandom_range(0, 2) == 0);
            cfg_ch     = CHW'($urandom_range(0, 3));
            cfg_period = W'($urandom_range(0, 9));
            cfg_high   = W'($urandom_range(0, 10));
            #1;
            checks++;
            if (cfg_ready !== exp_ready()) begin
                errors++;
                $display("FAIL rand_ready k=%0d got %b exp %b",
                         k, cfg_ready, exp_ready());
            end
            tick();
            checks++;
            if ({wave_out, rise_pulse, fall_pulse, cfg_err}
                !== {m_wave, m_rise, m_fall, m_err}) begin
                errors++;
                $display("FAIL rand k=%0d got %b exp %b", k,
                         {wave_out, rise_pulse, fall_pulse, cfg_err},
                         {m_wave, m_rise, m_fall, m_err});
            end
        end
        reset = 1'b0;
        cfg_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_default();
        test_cfg_idle();
        test_update();
        test_errors();
        test_disable();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clkgen_multi.md
Name: clkgen_multi

Overview:
- Synthesizable, parametrised successor to the bench-only free-running clock generator.
- Produces NUM_CH independent divided waveforms from one system clock.
- Each channel has a run-time programmable period and high time, plus single-cycle rise/fall strobes.
- Used as the shared strobe/clock-enable source for bench and RTL blocks.

Parameters:
NUM_CH, 4, number of independent output channels (1..16)
CNT_W, 8, width of period/high-time counters; max period 2**CNT_W-1 cycles
DEF_PERIOD, 2, period loaded at reset (must be >=2 and fit CNT_W)
DEF_HIGH, 1, high time loaded at reset (<= DEF_PERIOD)

Ports:
clock  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
enable  in  NUM_CH  per-channel run enable
cfg_valid  in  1  config request
cfg_ready  out  1  config accepted this cycle when cfg_valid&&cfg_ready
cfg_ch  in  $clog2(NUM_CH) (min 1)  target channel
cfg_period  in  CNT_W  new period in clock cycles
cfg_high  in  CNT_W  new high time in clock cycles
cfg_err  out  1  one-cycle pulse: request rejected
wave_out  out  NUM_CH  divided waveform, registered
rise_pulse  out  NUM_CH  one-cycle pulse on wave_out 0->1
fall_pulse  out  NUM_CH  one-cycle pulse on wave_out 1->0

Behaviour:
- Reset (sync, priority over everything):
  - per channel: state IDLE, cnt=0, period=DEF_PERIOD, high=DEF_HIGH, no pending shadow.
  - all outputs 0; cfg_ready=0 during reset, 1 the cycle after.
- Per-channel FSM:
  - IDLE: cnt held 0; wave_out, rise_pulse, fall_pulse driven to 0.
  - IDLE->RUN when enable[i]=1. First RUN cycle has cnt=0.
  - RUN->IDLE when enable[i]=0. Takes effect next cycle; if wave_out was 1, fall_pulse fires that cycle.
- Counter in RUN: cnt <= (cnt==period-1) ? 0 : cnt+1.
- Output, 1-cycle latency: wave_out(t+1) = RUN(t) && (cnt(t) < high).
  - high=0: always low.
  - high>=period: always high after the first cycle, no further strobes.
- Strobes: rise_pulse(t) = wave_out(t)&&!wave_out(t-1); fall_pulse likewise; both registered, mutually exclusive.
- Config handshake:
  - Accepted when cfg_valid && cfg_ready.
  - cfg_ready=0 only while the addressed cfg_ch already holds a pending shadow.
  - Reject when cfg_period<2, cfg_high>cfg_period, or cfg_ch>=NUM_CH. Rejected request: cfg_err pulses next cycle, nothing stored, still counts as a handshake.
  - Accepted values go to a per-channel shadow.
- Shadow apply, glitch-free:
  - Channel IDLE: applied on the next clock.
  - Channel RUN: applied on the cycle cnt wraps from period-1 to 0; the new period starts at cnt=0.
  - After apply the pending flag clears; cfg_ready returns to 1 for that channel the same cycle.
- Simultaneous events:
  - Wrap and accept to the same channel in one cycle: the new request goes to shadow, applies at the next wrap.
  - enable drop with pending shadow: shadow applies while IDLE.
  - reset clears pending shadows.
- Channels are fully independent. One config port, one request per cycle.
- Widths: cnt, period and high are CNT_W unsigned; no arithmetic overflow, since period<=2**CNT_W-1.

Test Plan:
- Reset, then enable[0]=1 with defaults -> wave_out[0] toggles every cycle (period 2, high 1); first rise_pulse[0] 1 cycle after enable.
- Configure ch1 period=5 high=2 while IDLE, then enable -> wave_out[1] high 2 cycles, low 3, repeating; rise/fall pulses 5 cycles apart, offset 2.
- ch1 running period=5; request period=3 high=1 mid-period -> old 5-cycle period completes, next period is 3 cycles; a second request before apply sees cfg_ready=0.
- Requests period=1, then high=6/period=4, then cfg_ch=NUM_CH -> cfg_err pulse each time; ch waveforms unchanged.
- enable[2] dropped while wave_out[2]=1 -> fall_pulse[2] next cycle, then all ch2 outputs 0; re-enable restarts at cnt=0.
- reset asserted mid-run with pending shadow -> all outputs 0 next cycle; shadow discarded; defaults (period 2) on re-enable.
